// File: rtl/router_pkg.sv
// Shared router definitions: flit control-bit offsets and output-arbiter state encoding.
package router_pkg;

  // Offsets below FLIT_W: head = FLIT_W-HEAD_BIT, tail = FLIT_W-TAIL_BIT
  localparam int HEAD_BIT = 1;
  localparam int TAIL_BIT = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter; the search starts at ptr and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/link_output_arbiter.sv
// Output-port stage: round-robin, wormhole-atomic packet forwarding from NUM_IN
// upstream buffers onto the link, with credit-based downstream flow control.
//
// state     | meaning
// ST_IDLE   | no packet locked; arbitrate among non-empty buffers
// ST_STREAM | packet from buffer `grant` locked until its tail is forwarded
module link_output_arbiter
  import router_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int FLIT_W  = 64,
  parameter int CREDITS = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_empty,
  input  logic [NUM_IN*FLIT_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_consume,
  input  logic                     credit_in,
  output logic [FLIT_W-1:0]        out_flit,
  output logic                     out_valid
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_IN - 1);

  arb_state_t        state;
  logic              inflight;
  logic [IW-1:0]     grant;
  logic [IW-1:0]     rr_ptr;
  logic [CW-1:0]     credits;

  logic [NUM_IN-1:0] arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic [FLIT_W-1:0] grant_flit;
  logic              grant_tail;
  logic              have_credit;
  logic              consume_any;

  rr_arbiter #(.N(NUM_IN), .IW(IW)) u_rr_arbiter (
    .req     (~in_empty),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign grant_flit  = in_data[int'(grant)*FLIT_W +: FLIT_W];
  assign grant_tail  = grant_flit[FLIT_W-TAIL_BIT];
  assign have_credit = (credits != '0);

  // Pop decision peeks the tail of the flit already on in_data so we never pop past it.
  always_comb begin
    in_consume = '0;
    if (state == ST_IDLE) begin
      if (have_credit) in_consume = arb_gnt;
    end else if (have_credit && !in_empty[grant] && !(inflight && grant_tail)) begin
      in_consume[grant] = 1'b1;
    end
  end

  assign consume_any = |in_consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      inflight  <= 1'b0;
      grant     <= '0;
      rr_ptr    <= '0;
      credits   <= CRED_MAX;
      out_flit  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (consume_any) begin
            grant    <= arb_idx;
            rr_ptr   <= (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
            inflight <= 1'b1;
            state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (inflight) begin
            out_flit  <= grant_flit;
            out_valid <= 1'b1;
          end
          if (inflight && grant_tail) begin
            inflight <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            inflight <= consume_any;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A pop reserves its downstream slot; a return with the counter full is dropped.
      if (consume_any && !credit_in) begin
        credits <= credits - 1'b1;
      end else if (credit_in && !consume_any && credits != CRED_MAX) begin
        credits <= credits + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && credit_in && !consume_any) begin
      assert (credits != CRED_MAX)
        else $warning("credit returned while counter already at %0d; saturating", CREDITS);
    end
  end

endmodule

// File: tb/tb_link_output_arbiter.sv
// Directed bench for link_output_arbiter with a behavioural model of the upstream buffers.
module tb_link_output_arbiter;

  localparam int NUM_IN  = 4;
  localparam int FLIT_W  = 64;
  localparam int CREDITS = 7;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_IN-1:0]        in_empty;
  logic [NUM_IN*FLIT_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_consume;
  logic                     credit_in;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_valid;

  always #5 clk = ~clk;

  link_output_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_empty   (in_empty),
    .in_data    (in_data),
    .in_consume (in_consume),
    .credit_in  (credit_in),
    .out_flit   (out_flit),
    .out_valid  (out_valid)
  );

  logic [FLIT_W-1:0] q [NUM_IN][$];
  logic [FLIT_W-1:0] out_log [$];
  int                out_cyc [$];
  int  cyc, n_pass, n_total, onehot_err, pop_err, n_cons, stray, c0;
  bit  auto_cr;
  logic [FLIT_W-1:0] exp_f [$];

  function automatic logic [FLIT_W-1:0] mk(bit h, bit t, logic [FLIT_W-3:0] p);
    return {h, t, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic refresh_empty();
    for (int i = 0; i < NUM_IN; i++) in_empty[i] = (q[i].size() == 0);
    #1;
  endtask

  // Called at (or just after) a negedge; returns at the next negedge.
  task automatic tick(input bit cr = 1'b0);
    logic [NUM_IN-1:0] c;
    logic r;
    c = in_consume;
    credit_in = cr | (auto_cr & out_valid);
    @(posedge clk);
    r = rst;
    #1;
    if (r) begin
      for (int i = 0; i < NUM_IN; i++) q[i].delete();
      in_data = '0;
    end else begin
      if ($countones(c) > 1) onehot_err++;
      n_cons += $countones(c);
      for (int i = 0; i < NUM_IN; i++) begin
        if (c[i]) begin
          if (q[i].size() == 0) pop_err++;
          else in_data[i*FLIT_W +: FLIT_W] = q[i].pop_front();
        end
      end
    end
    for (int i = 0; i < NUM_IN; i++) in_empty[i] = (q[i].size() == 0);
    cyc++;
    @(negedge clk);
    if (out_valid) begin
      out_log.push_back(out_flit);
      out_cyc.push_back(cyc);
    end
  endtask

  initial begin
    rst = 1'b1; in_empty = '1; in_data = '0; credit_in = 1'b0; auto_cr = 1'b0;
    cyc = 0; n_pass = 0; n_total = 0; onehot_err = 0; pop_err = 0; n_cons = 0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_consume", in_consume, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_credits", dut.credits, CREDITS);
    chk("rst_rr_ptr", dut.rr_ptr, 0);

    // Four 3-flit packets, rr_ptr=0: order 0,1,2,3 with one bubble between packets
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 3; j++) q[p].push_back(mk(j == 0, j == 2, 62'(p*16 + j)));
    refresh_empty();
    auto_cr = 1'b1;
    out_log.delete(); out_cyc.delete();
    c0 = cyc;
    for (int k = 0; k < 40 && out_log.size() < 12; k++) tick();
    chk("rr4_count", out_log.size(), 12);
    if (out_log.size() == 12) begin
      chk("rr4_latency", out_cyc[0] - c0, 2);
      for (int k = 0; k < 12; k++)
        chk($sformatf("rr4_flit%0d", k), out_log[k], mk(k % 3 == 0, k % 3 == 2, 62'((k/3)*16 + k%3)));
      for (int k = 1; k < 12; k++)
        chk($sformatf("rr4_gap%0d", k), out_cyc[k] - out_cyc[k-1], (k % 3 == 0) ? 2 : 1);
    end
    repeat (4) tick();
    auto_cr = 1'b0;
    chk("rr4_credits_back", dut.credits, CREDITS);
    chk("rr4_rr_ptr", dut.rr_ptr, 0);

    // Single-flit packet in buffer 2
    q[2].push_back(mk(1, 1, 62'h2A));
    refresh_empty();
    chk("single_consume", in_consume, 4'b0100);
    tick();
    chk("single_consume_off", in_consume, 0);
    chk("single_no_valid_yet", out_valid, 0);
    chk("single_credits", dut.credits, 6);
    chk("single_rr_ptr", dut.rr_ptr, 3);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_flit", out_flit, mk(1, 1, 62'h2A));
    tick();
    chk("single_valid_once", out_valid, 0);

    // credit_in coinciding with a consume, then a return with the counter full
    q[1].push_back(mk(1, 1, 62'h1B));
    refresh_empty();
    chk("coinc_consume", in_consume, 4'b0010);
    tick(1'b1);
    chk("coinc_credits", dut.credits, 6);
    tick();
    chk("coinc_valid", out_valid, 1);
    chk("coinc_flit", out_flit, mk(1, 1, 62'h1B));
    tick(1'b1);
    chk("credit_return", dut.credits, 7);
    tick(1'b1);
    chk("credit_saturate", dut.credits, 7);

    // 10-flit packet against 7 credits
    for (int j = 0; j < 10; j++) q[1].push_back(mk(j == 0, j == 9, 62'(12'h300 + j)));
    refresh_empty();
    out_log.delete(); out_cyc.delete();
    n_cons = 0;
    repeat (20) tick();
    chk("cred_stall_consumes", n_cons, 7);
    chk("cred_stall_outputs", out_log.size(), 7);
    chk("cred_stall_consume_low", in_consume, 0);
    chk("cred_stall_credits", dut.credits, 0);
    tick(1'b1);
    chk("cred_one_consume", in_consume, 4'b0010);
    tick(); tick();
    chk("cred_one_valid", out_valid, 1);
    chk("cred_one_flit", out_flit, mk(0, 0, 62'h307));
    repeat (5) tick();
    chk("cred_one_total_out", out_log.size(), 8);
    chk("cred_one_total_cons", n_cons, 8);

    // Reset with the packet still in progress
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_consume", in_consume, 0);
    chk("midrst_credits", dut.credits, CREDITS);
    chk("midrst_rr_ptr", dut.rr_ptr, 0);

    // Source empties mid-packet; lock must hold on port 0 while port 3 waits
    auto_cr = 1'b1;
    q[0].push_back(mk(1, 0, 62'h400));
    q[0].push_back(mk(0, 0, 62'h401));
    q[3].push_back(mk(1, 1, 62'h43));
    refresh_empty();
    out_log.delete(); out_cyc.delete();
    chk("hold_first_consume", in_consume, 4'b0001);
    tick(); tick();
    stray = 0;
    repeat (5) begin
      if (in_consume != '0) stray++;
      tick();
    end
    chk("hold_no_grant", stray, 0);
    q[0].push_back(mk(0, 0, 62'h402));
    q[0].push_back(mk(0, 1, 62'h403));
    refresh_empty();
    chk("hold_resume_port0", in_consume, 4'b0001);
    for (int k = 0; k < 30 && out_log.size() < 5; k++) tick();
    exp_f = '{mk(1, 0, 62'h400), mk(0, 0, 62'h401), mk(0, 0, 62'h402), mk(0, 1, 62'h403), mk(1, 1, 62'h43)};
    chk("hold_count", out_log.size(), 5);
    if (out_log.size() == 5)
      for (int k = 0; k < 5; k++) chk($sformatf("hold_flit%0d", k), out_log[k], exp_f[k]);

    chk("onehot_consume", onehot_err, 0);
    chk("no_empty_pop", pop_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
